// File: rtl/operand_stack.sv
// ============================================================================
//  Module      : operand_stack
//  Description : Parametrised operand stack (top/pen exposed to the ALU) with
//                occupancy count and sticky overflow/underflow detection.
//                Optional peek port enabled by defining OPSTACK_PEEK_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module operand_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             start_n,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] pen,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf,
  output logic             err,
  input  logic [CW-1:0]    peek_idx,
  output logic [WIDTH-1:0] peek_data
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] c_op_nop     = 3'b000;
  localparam logic [2:0] c_op_push    = 3'b001;
  localparam logic [2:0] c_op_pop     = 3'b010;
  localparam logic [2:0] c_op_dup     = 3'b011;
  localparam logic [2:0] c_op_swap    = 3'b100;
  localparam logic [2:0] c_op_reduce  = 3'b101;
  localparam logic [2:0] c_op_replace = 3'b110;
  localparam logic [2:0] c_op_clear   = 3'b111;

  localparam logic [CW-1:0] c_one   = CW'(1);
  localparam logic [CW-1:0] c_two   = CW'(2);
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [AW-1:0]    w_push_a;
  logic [AW-1:0]    w_top_a;
  logic [AW-1:0]    w_pen_a;
  logic             w_has1;
  logic             w_has2;
  logic             w_full;

  // Addresses are truncated to the array width; each is only used when in range.
  assign w_push_a = AW'(count_q);
  assign w_top_a  = AW'(count_q - c_one);
  assign w_pen_a  = AW'(count_q - c_two);
  assign w_has1   = (count_q >= c_one);
  assign w_has2   = (count_q >= c_two);
  assign w_full   = (count_q == c_depth);

  assign top   = w_has1 ? mem_q[w_top_a] : '0;
  assign pen   = w_has2 ? mem_q[w_pen_a] : '0;
  assign count = count_q;
  assign empty = ~w_has1;
  assign full  = w_full;
  assign ovf   = ovf_q;
  assign unf   = unf_q;
  assign err   = ovf_q | unf_q;

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    case (op)
      c_op_nop: ;
      c_op_push: begin
        if (!w_full) begin
          mem_d[w_push_a] = din;
          count_d         = count_q + c_one;
        end else begin
          ovf_d = 1'b1;
        end
      end
      c_op_pop: begin
        if (w_has1) count_d = count_q - c_one;
        else        unf_d   = 1'b1;
      end
      c_op_dup: begin
        if (!w_has1) begin
          unf_d = 1'b1;
        end else if (w_full) begin
          ovf_d = 1'b1;
        end else begin
          mem_d[w_push_a] = mem_q[w_top_a];
          count_d         = count_q + c_one;
        end
      end
      c_op_swap: begin
        if (w_has2) begin
          mem_d[w_top_a] = mem_q[w_pen_a];
          mem_d[w_pen_a] = mem_q[w_top_a];
        end else begin
          unf_d = 1'b1;
        end
      end
      c_op_reduce: begin
        if (w_has2) begin
          mem_d[w_pen_a] = din;
          count_d        = count_q - c_one;
        end else begin
          unf_d = 1'b1;
        end
      end
      c_op_replace: begin
        if (w_has1) mem_d[w_top_a] = din;
        else        unf_d          = 1'b1;
      end
      c_op_clear: begin
        count_d = '0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge start_n) begin
    if (!start_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is left unreset; reads are masked by count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef OPSTACK_PEEK_EN
  logic [CW-1:0] w_peek_pos;
  logic          w_peek_ok;

  assign w_peek_pos = count_q - c_one - peek_idx;
  assign w_peek_ok  = (peek_idx < count_q);
  assign peek_data  = w_peek_ok ? mem_q[AW'(w_peek_pos)] : '0;
`else
  logic unused_peek_idx;

  assign unused_peek_idx = ^peek_idx;
  assign peek_data       = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_operand_stack.sv
// ============================================================================
//  Module      : tb_operand_stack
//  Description : Directed self-checking bench for operand_stack (WIDTH=8,
//                DEPTH=16); covers OPSTACK_PEEK_EN in either build.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_operand_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  localparam logic [2:0] c_nop     = 3'b000;
  localparam logic [2:0] c_push    = 3'b001;
  localparam logic [2:0] c_pop     = 3'b010;
  localparam logic [2:0] c_dup     = 3'b011;
  localparam logic [2:0] c_swap    = 3'b100;
  localparam logic [2:0] c_reduce  = 3'b101;
  localparam logic [2:0] c_replace = 3'b110;
  localparam logic [2:0] c_clear   = 3'b111;

  logic             clk;
  logic             start_n;
  logic [2:0]       op;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] pen;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             ovf;
  logic             unf;
  logic             err;
  logic [CW-1:0]    peek_idx;
  logic [WIDTH-1:0] peek_data;

  int checks;
  int errors;

  operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .start_n   (start_n),
    .op        (op),
    .din       (din),
    .top       (top),
    .pen       (pen),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .ovf       (ovf),
    .unf       (unf),
    .err       (err),
    .peek_idx  (peek_idx),
    .peek_data (peek_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one op across a single rising edge; returns 1ns after the edge.
  task automatic do_op(input logic [2:0] o, input logic [WIDTH-1:0] d);
    @(negedge clk);
    op  = o;
    din = d;
    @(posedge clk);
    #1;
    op  = c_nop;
    din = 8'hEE;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    op       = c_nop;
    din      = '0;
    peek_idx = '0;
    start_n  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start_n = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full",  32'(full),  0);
    chk("rst_top",   32'(top),   0);
    chk("rst_pen",   32'(pen),   0);
    chk("rst_err",   32'(err),   0);

    do_op(c_push, 8'h11);
    do_op(c_push, 8'h22);
    do_op(c_push, 8'h33);
    chk("push3_top",   32'(top),   32'h33);
    chk("push3_pen",   32'(pen),   32'h22);
    chk("push3_count", 32'(count), 3);
    do_op(c_nop, 8'h99);
    chk("nop_top", 32'(top), 32'h33);
    do_op(c_swap, 8'h99);
    chk("swap_top", 32'(top), 32'h22);
    chk("swap_pen", 32'(pen), 32'h33);
    do_op(c_reduce, 8'h55);
    chk("reduce_top",   32'(top),   32'h55);
    chk("reduce_pen",   32'(pen),   32'h11);
    chk("reduce_count", 32'(count), 2);
    do_op(c_reduce, 8'h66);
    chk("reduce2_count", 32'(count), 1);
    chk("reduce2_pen",   32'(pen),   0);
    chk("reduce2_top",   32'(top),   32'h66);
    do_op(c_pop, 8'h00);
    chk("pop_empty_top", 32'(top),   0);
    chk("pop_empty",     32'(empty), 1);
    chk("pop_no_unf",    32'(unf),   0);

    for (int i = 0; i < 16; i++) do_op(c_push, 8'(i));
    chk("fill_full",  32'(full),  1);
    chk("fill_ovf",   32'(ovf),   0);
    chk("fill_count", 32'(count), 16);
    do_op(c_push, 8'h10);
    chk("ovf_flag",  32'(ovf),   1);
    chk("ovf_err",   32'(err),   1);
    chk("ovf_count", 32'(count), 16);
    chk("ovf_top",   32'(top),   32'h0F);
    do_op(c_dup, 8'h00);
    chk("dupfull_unf",   32'(unf),   0);
    chk("dupfull_count", 32'(count), 16);
    do_op(c_pop, 8'h00);
    chk("popfull_top",   32'(top),   32'h0E);
    chk("popfull_ovf",   32'(ovf),   1);
    chk("popfull_count", 32'(count), 15);
    chk("popfull_full",  32'(full),  0);
    do_op(c_clear, 8'h00);
    chk("clr_count", 32'(count), 0);
    chk("clr_ovf",   32'(ovf),   0);

    do_op(c_pop, 8'h00);
    chk("unf_pop",       32'(unf),   1);
    chk("unf_pop_count", 32'(count), 0);
    do_op(c_clear, 8'h00);
    do_op(c_push, 8'h07);
    do_op(c_swap, 8'h00);
    chk("unf_swap",       32'(unf),   1);
    chk("unf_swap_count", 32'(count), 1);
    chk("unf_swap_top",   32'(top),   32'h07);
    do_op(c_clear, 8'h00);
    do_op(c_push, 8'h07);
    do_op(c_reduce, 8'h09);
    chk("unf_red",       32'(unf),   1);
    chk("unf_red_count", 32'(count), 1);
    chk("unf_red_top",   32'(top),   32'h07);
    chk("unf_red_ovf",   32'(ovf),   0);
    do_op(c_clear, 8'h00);
    chk("clr_unf", 32'(unf), 0);
    chk("clr_err", 32'(err), 0);
    do_op(c_dup, 8'h00);
    chk("unf_dup", 32'(unf), 1);
    do_op(c_clear, 8'h00);
    do_op(c_replace, 8'h12);
    chk("unf_repl",       32'(unf),   1);
    chk("unf_repl_count", 32'(count), 0);

    // unf remains set from REPLACE; ops continue to execute normally.
    do_op(c_push, 8'hA5);
    do_op(c_dup, 8'h00);
    do_op(c_replace, 8'h3C);
    chk("dr_count",  32'(count), 2);
    chk("dr_top",    32'(top),   32'h3C);
    chk("dr_pen",    32'(pen),   32'hA5);
    chk("dr_sticky", 32'(unf),   1);

    @(negedge clk);
    op  = c_push;
    din = 8'h77;
    #2;
    start_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_err",   32'(err),   0);
    @(posedge clk);
    #1;
    chk("arst_hold", 32'(count), 0);
    op = c_nop;
    @(negedge clk);
    start_n = 1'b1;
    @(negedge clk);
    chk("arst_rel_count", 32'(count), 0);

    do_op(c_push, 8'h01);
    do_op(c_push, 8'h02);
    do_op(c_push, 8'h03);
    do_op(c_push, 8'h04);
    for (int i = 0; i <= 4; i++) begin
      logic [31:0] exp_pk;
`ifdef OPSTACK_PEEK_EN
      exp_pk = (i < 4) ? 32'(4 - i) : 32'd0;
`else
      exp_pk = 32'd0;
`endif
      peek_idx = CW'(i);
      #1;
      chk($sformatf("peek%0d", i), 32'(peek_data), exp_pk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
